// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply / restoring divide engine; sole writer of HI/LO.
// Optional unsigned operations (multu/divu) via `define MULDIV_UNSIGNED_EN.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             unsigned_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hilo_wr,
    output logic             ready,
    output logic             busy,
    output logic             div_zero
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MULT  = 3'd1,
        S_DIV   = 3'd2,
        S_DONE  = 3'd3,
        S_DZERO = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // iteration state
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] mcand;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             sign;
    logic             qsign;
    logic             rsign;

    // next-cycle values of the registered outputs
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             hilo_wr_d;
    logic             ready_d;
    logic             busy_d;
    logic             div_zero_d;

    logic             signed_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             take_mult;
    logic             take_div;

    logic [WIDTH:0]   mult_sum;
    logic [AW-1:0]    acc_nxt;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [AW-1:0]    prod_fin;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

`ifdef MULDIV_UNSIGNED_EN
    assign signed_op = ~unsigned_op;
`else
    assign signed_op = 1'b1;
`endif

    // Operand magnitudes; |most-negative| is representable as WIDTH-bit unsigned.
    assign a_mag  = (signed_op && a[WIDTH-1]) ? WIDTH'(-a) : a;
    assign b_mag  = (signed_op && b[WIDTH-1]) ? WIDTH'(-b) : b;
    assign b_zero = (b == '0);

    // Multiply has priority when both starts arrive together.
    assign take_mult = (state == S_IDLE) && mult_start;
    assign take_div  = (state == S_IDLE) && !mult_start && div_start;

    // One shift-add step: low half of acc holds the remaining multiplier bits.
    assign mult_sum = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_nxt  = {mult_sum, acc[WIDTH-1:1]};

    // One restoring-divide step: quo shifts dividend bits out and quotient bits in.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, divisor});
    assign rem_nxt   = div_ge ? WIDTH'(div_shift - {1'b0, divisor}) : div_shift[WIDTH-1:0];
    assign quo_nxt   = {quo[WIDTH-2:0], div_ge};

    // Sign fix-up applied to the final iteration result.
    assign prod_fin = sign  ? AW'(-acc_nxt)    : acc_nxt;
    assign quo_fin  = qsign ? WIDTH'(-quo_nxt) : quo_nxt;
    assign rem_fin  = rsign ? WIDTH'(-rem_nxt) : rem_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take_mult) begin
                    state_nxt = S_MULT;
                end else if (take_div) begin
                    state_nxt = b_zero ? S_DZERO : S_DIV;
                end
            end
            S_MULT:  if (counter == '0) state_nxt = S_DONE;
            S_DIV:   if (counter == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_DZERO: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: results land in the registers as the state enters DONE/DZERO.
    always_comb begin
        hi_d       = hi_out;
        lo_d       = lo_out;
        hilo_wr_d  = 1'b0;
        ready_d    = 1'b0;
        div_zero_d = 1'b0;
        busy_d     = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: begin
                if (take_div && b_zero) begin
                    div_zero_d = 1'b1;
                    ready_d    = 1'b1;
                end
            end
            S_MULT: begin
                if (counter == '0) begin
                    hi_d      = prod_fin[AW-1:WIDTH];
                    lo_d      = prod_fin[WIDTH-1:0];
                    hilo_wr_d = 1'b1;
                    ready_d   = 1'b1;
                end
            end
            S_DIV: begin
                if (counter == '0) begin
                    hi_d      = rem_fin;
                    lo_d      = quo_fin;
                    hilo_wr_d = 1'b1;
                    ready_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_out   <= '0;
            lo_out   <= '0;
            hilo_wr  <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            hi_out   <= hi_d;
            lo_out   <= lo_d;
            hilo_wr  <= hilo_wr_d;
            ready    <= ready_d;
            busy     <= busy_d;
            div_zero <= div_zero_d;
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            mcand   <= '0;
            acc     <= '0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            sign    <= 1'b0;
            qsign   <= 1'b0;
            rsign   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take_mult) begin
                        mcand   <= a_mag;
                        acc     <= {{WIDTH{1'b0}}, b_mag};
                        sign    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        counter <= CW'(WIDTH - 1);
                    end else if (take_div && !b_zero) begin
                        divisor <= b_mag;
                        quo     <= a_mag;
                        rem     <= '0;
                        qsign   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rsign   <= signed_op & a[WIDTH-1];
                        counter <= CW'(WIDTH - 1);
                    end
                end
                S_MULT: begin
                    acc <= acc_nxt;
                    if (counter != '0) counter <= counter - CW'(1);
                end
                S_DIV: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    if (counter != '0) counter <= counter - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, signed results, div-by-zero,
// start priority, busy-time starts and mid-operation reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hilo_wr;
    logic        ready;
    logic        busy;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .hilo_wr    (hilo_wr),
        .ready      (ready),
        .busy       (busy),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation (start high in cycle 0) and return the cycle of ready.
    // With inject set, a multiply start with other operands is pulsed in cycle 5.
    task automatic run_op(input logic m, input logic d, input logic [31:0] av,
                          input logic [31:0] bv, input bit inject, output int cyc);
        a = av;
        b = bv;
        mult_start = m;
        div_start  = d;
        tick();
        mult_start = 1'b0;
        div_start  = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_0003;
        cyc = 1;
        while (!ready && cyc < 100) begin
            if (inject && cyc == 5) mult_start = 1'b1;
            tick();
            mult_start = 1'b0;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int ready_seen;

        reset = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        check("rst_hi",       64'(hi_out),   64'h0);
        check("rst_lo",       64'(lo_out),   64'h0);
        check("rst_flags",    64'({hilo_wr, ready, busy, div_zero}), 64'h0);
        reset = 1'b0;
        tick();

        // 7 * -3 = -21, with an ignored start pulse in cycle 5
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, cyc);
        check("mul_latency",  64'(cyc),      64'd33);
        check("mul_wr_rdy",   64'({hilo_wr, ready, busy}), 64'h7);
        check("mul_hi",       64'(hi_out),   64'hFFFF_FFFF);
        check("mul_lo",       64'(lo_out),   64'hFFFF_FFEB);
        tick();
        check("mul_after",    64'({hilo_wr, ready, busy}), 64'h0);

        // -7 / 2 = -3 rem -1, started in the first cycle start is accepted again
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
        check("div_latency",  64'(cyc),      64'd33);
        check("div_lo",       64'(lo_out),   64'hFFFF_FFFD);
        check("div_hi",       64'(hi_out),   64'hFFFF_FFFF);
        check("div_wr",       64'({hilo_wr, div_zero}), 64'h2);
        tick();

        // most-negative / -1 wraps
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
        check("wrap_lo",      64'(lo_out),   64'h8000_0000);
        check("wrap_hi",      64'(hi_out),   64'h0);
        tick();

        // divide by zero: one-cycle pulse, HI/LO hold
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, cyc);
        check("dz_latency",   64'(cyc),      64'd1);
        check("dz_flags",     64'({div_zero, ready, hilo_wr, busy}), 64'hD);
        check("dz_hold_lo",   64'(lo_out),   64'h8000_0000);
        check("dz_hold_hi",   64'(hi_out),   64'h0);
        tick();
        check("dz_after",     64'({div_zero, ready, busy}), 64'h0);

        // both starts: multiply only
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, cyc);
        check("both_latency", 64'(cyc),      64'd33);
        check("both_hi",      64'(hi_out),   64'h4000_0000);
        check("both_lo",      64'(lo_out),   64'h0);
        check("both_dz",      64'(div_zero), 64'h0);
        tick();

        // reset in cycle 10 of a multiply aborts it
        a = 32'd3;
        b = 32'd4;
        mult_start = 1'b1;
        tick();
        mult_start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hilo",   {hi_out, lo_out}, 64'h0);
        check("abort_flags",  64'({hilo_wr, ready, busy, div_zero}), 64'h0);
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready || hilo_wr) ready_seen++;
            tick();
        end
        check("abort_noready", 64'(ready_seen), 64'h0);

        // 100 / 7 = 14 rem 2 after the abort
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, cyc);
        check("post_latency", 64'(cyc),      64'd33);
        check("post_lo",      64'(lo_out),   64'd14);
        check("post_hi",      64'(hi_out),   64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
